// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the sequential divider.
package div_pkg;

   localparam int unsigned DIV_WIDTH = 16;

   typedef logic [DIV_WIDTH-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   // Quotient returned for a zero divisor.
   localparam word_t DIV0_QUOT    = '1;
   // Most negative dividend; with a divisor of -1 this is the signed overflow case.
   localparam word_t OVF_DIVIDEND = {1'b1, {(DIV_WIDTH-1){1'b0}}};

   // Magnitude of a two's-complement value when signed, raw bits otherwise.
   function automatic word_t abs_w(input word_t value, input logic signed_op);
      return (signed_op && value[DIV_WIDTH-1]) ? word_t'(-value) : value;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract.
module div_step #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH:0]   prem,
   input  logic [WIDTH-1:0] qreg,
   input  logic [WIDTH-1:0] divisor_abs,
   output logic [WIDTH:0]   prem_next,
   output logic [WIDTH-1:0] qreg_next
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;

   // prem < divisor always holds, so one extra bit is enough for a reliable sign.
   always_comb begin
      shifted = {prem, qreg[WIDTH-1]};
      trial   = shifted - {2'b00, divisor_abs};
      if (!trial[WIDTH+1]) begin
         prem_next = trial[WIDTH:0];
         qreg_next = {qreg[WIDTH-2:0], 1'b1};
      end else begin
         prem_next = shifted[WIDTH:0];
         qreg_next = {qreg[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div16_seq.sv
// Iterative radix-2 restoring divider, signed/unsigned, RISC-V corner-case results.
module div16_seq
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             signed_op,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   div_state_t       state_q, state_d;
   logic [WIDTH:0]   prem_q, prem_step;
   logic [WIDTH-1:0] qreg_q, qreg_step;
   logic [WIDTH-1:0] divisor_abs_q;
   logic [WIDTH-1:0] quot_q, rem_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_q_q, neg_r_q;
   logic             accept, div_zero, sign_ovf;

   assign accept   = in_valid & (state_q == IDLE) & ~kill;
   assign div_zero = (divisor == '0);
   assign sign_ovf = signed_op & (dividend == OVF_DIVIDEND) & (divisor == DIV0_QUOT);

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .prem        (prem_q),
      .qreg        (qreg_q),
      .divisor_abs (divisor_abs_q),
      .prem_next   (prem_step),
      .qreg_next   (qreg_step)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; kill overrides everything.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = (div_zero || sign_ovf) ? DONE : CALC;
         CALC: if (cnt_q == '0) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (kill) state_d = IDLE;
   end

   // Handshake and status outputs.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
   end

   assign quot = quot_q;
   assign rem  = rem_q;

   // Datapath: operand capture, iteration, sign fix-up, special-case results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prem_q        <= '0;
         qreg_q        <= '0;
         divisor_abs_q <= '0;
         neg_q_q       <= 1'b0;
         neg_r_q       <= 1'b0;
         cnt_q         <= '0;
         quot_q        <= '0;
         rem_q         <= '0;
      end else if (!kill) begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  if (div_zero) begin
                     quot_q <= DIV0_QUOT;
                     rem_q  <= dividend;
                  end else if (sign_ovf) begin
                     quot_q <= dividend;
                     rem_q  <= '0;
                  end else begin
                     prem_q        <= '0;
                     qreg_q        <= abs_w(dividend, signed_op);
                     divisor_abs_q <= abs_w(divisor, signed_op);
                     neg_q_q       <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     neg_r_q       <= signed_op & dividend[WIDTH-1];
                     cnt_q         <= CNT_W'(WIDTH - 1);
                  end
               end
            end
            CALC: begin
               prem_q <= prem_step;
               qreg_q <= qreg_step;
               if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end
            FIX: begin
               quot_q <= neg_q_q ? (WIDTH)'(-qreg_q) : qreg_q;
               rem_q  <= neg_r_q ? (WIDTH)'(-prem_q[WIDTH-1:0]) : prem_q[WIDTH-1:0];
            end
            DONE: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div16_seq.sv
// Directed, table-driven bench for div16_seq plus hand-written handshake/kill/reset sequences.
module tb_div16_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [15:0] dividend, divisor;
   logic        signed_op, kill;
   logic        out_valid, out_ready;
   logic [15:0] quot, rem;
   logic        busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic [15:0] q;
      logic [15:0] r;
      int          lat;
   } vec_t;

   vec_t vecs[15];

   div16_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .signed_op (signed_op),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quot      (quot),
      .rem       (rem),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Wait for in_ready, issue one operation; returns with out_valid sampled high (or timeout).
   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                           output int cycles, output logic busy_ok);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
      dividend  = a;
      divisor   = b;
      signed_op = s;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      cycles   = 1;
      in_valid = 1'b0;
      dividend = 16'hA5A5;   // must not disturb the captured operands
      divisor  = 16'h0003;
      signed_op = ~s;
      busy_ok  = 1'b1;
      while (!out_valid && cycles < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   cycles;
      logic busy_ok;
      start_op(v.a, v.b, v.s, cycles, busy_ok);
      chk({tag, "_latency"}, cycles, v.lat);
      chk({tag, "_quot"}, {16'd0, quot}, {16'd0, v.q});
      chk({tag, "_rem"}, {16'd0, rem}, {16'd0, v.r});
      if (v.lat > 1) chk({tag, "_busy_throughout"}, {31'd0, busy_ok}, 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_out_valid_after_hs"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_in_ready_after_hs"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int   cycles;
      logic busy_ok;
      logic seen;

      vecs[0]  = '{16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 18};
      vecs[1]  = '{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 18};
      vecs[2]  = '{16'hFFF9, 16'h0002, 1'b0, 16'h7FFC, 16'h0001, 18};
      vecs[3]  = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1};
      vecs[4]  = '{16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1};
      vecs[5]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1};
      vecs[6]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 18};
      vecs[7]  = '{16'h0032, 16'h0005, 1'b0, 16'h000A, 16'h0000, 18};
      vecs[8]  = '{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 18};
      vecs[9]  = '{16'hFF9C, 16'hFFF9, 1'b1, 16'h000E, 16'hFFFE, 18};
      vecs[10] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 18};
      vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 18};
      vecs[12] = '{16'h0000, 16'hFFFB, 1'b1, 16'h0000, 16'h0000, 18};
      vecs[13] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 16'h0000, 18};
      vecs[14] = '{16'hABCD, 16'h0100, 1'b0, 16'h00AB, 16'h00CD, 18};

      rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0;
      signed_op = 1'b0; kill = 1'b0; out_ready = 1'b0;
      #12;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_quot", {16'd0, quot}, 32'd0);
      chk("reset_rem", {16'd0, rem}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: result held while out_ready is low, no new accept.
      start_op(16'hFFFF, 16'h0001, 1'b0, cycles, busy_ok);
      chk("bp_latency", cycles, 18);
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
         chk("bp_quot_held", {16'd0, quot}, 32'h0000_FFFF);
         chk("bp_rem_held", {16'd0, rem}, 32'd0);
         chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_in_ready_after_hs", {31'd0, in_ready}, 32'd1);
      chk("bp_out_valid_after_hs", {31'd0, out_valid}, 32'd0);

      // kill together with in_valid in IDLE: no accept.
      dividend = 16'h0064; divisor = 16'h0007; signed_op = 1'b0;
      in_valid = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; kill = 1'b0;
      chk("kill_idle_no_accept", {31'd0, busy}, 32'd0);

      // kill at cycle 8 of CALC: back to IDLE, no result ever appears.
      dividend = 16'h0064; divisor = 16'h0007; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
      end
      chk("kill_calc_busy_before", {31'd0, busy}, 32'd1);
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill_calc_idle", {31'd0, busy}, 32'd0);
      chk("kill_calc_in_ready", {31'd0, in_ready}, 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("kill_no_out_valid", {31'd0, seen}, 32'd0);
      run_vec('{16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 18}, "after_kill");

      // kill in DONE together with out_ready: result discarded.
      start_op(16'h1234, 16'h0000, 1'b0, cycles, busy_ok);
      kill = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0; out_ready = 1'b0;
      chk("kill_done_out_valid", {31'd0, out_valid}, 32'd0);
      chk("kill_done_in_ready", {31'd0, in_ready}, 32'd1);

      // Asynchronous reset mid-CALC.
      dividend = 16'h0064; divisor = 16'h0007; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_quot", {16'd0, quot}, 32'd0);
      chk("rst_mid_rem", {16'd0, rem}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_vec('{16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 18}, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div16_seq.md
Name: div16_seq

Overview:
- Iterative radix-2 restoring divider: the inverse operation of the team's combinational 16x16 Booth multiplier.
- Serves the M-extension DIV/DIVU/REM/REMU path of the core.
- Accepts a dividend/divisor pair through a valid/ready handshake and iterates one quotient bit per cycle.
- Returns quotient and remainder through a second valid/ready handshake.
- Signed and unsigned operation, with RISC-V-defined results for divide-by-zero and signed overflow.

Parameters:
- WIDTH, 16, operand width in bits; only 16 is verified, and it must be even and at least 4.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  divider idle and able to accept.
- dividend  in  WIDTH  numerator.
- divisor  in  WIDTH  denominator.
- signed_op  in  1  1 = two's-complement operands (DIV/REM); 0 = unsigned (DIVU/REMU).
- kill  in  1  pipeline flush; aborts any operation.
- out_valid  out  1  quot/rem hold a valid result.
- out_ready  in  1  consumer accepts the result.
- quot  out  WIDTH  quotient.
- rem  out  WIDTH  remainder.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values: state = IDLE; in_ready = 1, out_valid = 0, busy = 0; quot = 0, rem = 0; iteration counter = 0.
- Operand capture: accept on the rising edge where in_valid & in_ready & ~kill. Call this edge T0. Operands are captured at T0 and later input changes are ignored.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On accept with divisor == 0: go to DONE with quot = all ones and rem = dividend (raw bits). This applies to both signed and unsigned operation.
  - On accept with signed_op & dividend == 100..0 & divisor == all ones: go to DONE with quot = dividend and rem = 0.
  - On any other accept: go to CALC.
  - Operand pre-processing on entry to CALC:
    - Take |dividend| and |divisor| when signed_op is set.
    - Latch neg_q = sign(dividend) ^ sign(divisor) and neg_r = sign(dividend); both are 0 when unsigned.
    - Partial remainder (WIDTH+1 bits) = 0; counter = WIDTH-1.
- CALC: one iteration per cycle, exactly WIDTH cycles (T1..T16 for WIDTH = 16).
  - Shift {prem, qreg} left by 1.
  - Trial subtract: t = prem - |divisor|, computed WIDTH+1 bits wide.
  - If t is non-negative: prem = t and qbit = 1. Otherwise keep prem and qbit = 0.
  - The counter decrements; when the counter is 0, go to FIX.
- FIX (one cycle, T17):
  - quot = neg_q ? -qreg : qreg.
  - rem = neg_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0].
  - Go to DONE.
- DONE:
  - out_valid = 1; quot/rem are held stable while out_valid & ~out_ready.
  - On out_valid & out_ready go to IDLE; in_ready rises the next cycle. There is no same-cycle re-accept.
- Latency:
  - Normal: out_valid is first high in the cycle after T17, i.e. WIDTH+2 = 18 cycles after accept.
  - Special cases: out_valid is high the cycle after accept.
- Arithmetic invariant: dividend == quot*divisor + rem, modulo 2^WIDTH. sign(rem) == sign(dividend) or rem == 0. Quotient truncates toward zero.
- kill:
  - In any state, kill forces IDLE on the next edge with out_valid = 0.
  - A pending undelivered result is discarded.
  - kill together with in_valid in IDLE: no accept.
  - kill together with out_ready in DONE: treated as kill, with no distinction.
- Reset mid-operation: immediate return to reset values; no partial result is visible.
- out_ready while not out_valid: ignored.
- in_valid while busy: ignored (in_ready = 0).

Decomposition:
- Shared package div_pkg:
  - state enum div_state_t {IDLE, CALC, FIX, DONE}.
  - Function abs_w(value, signed_op).
  - Constants DIV0_QUOT (all ones) and OVF_DIVIDEND (MSB only).
- Sub-module div_step:
  - Purely combinational single restoring iteration.
  - Inputs: prem, qreg, divisor_abs. Outputs: next prem, next qreg.
  - Instantiated once in div16_seq. The counter and FSM stay in the parent.

Test Plan:
- Unsigned 100/7: signed_op = 0, dividend = 0x0064, divisor = 0x0007 → quot = 0x000E, rem = 0x0002; out_valid exactly 18 cycles after accept; busy high throughout.
- Signed -7/2: dividend = 0xFFF9, divisor = 0x0002 → quot = 0xFFFD, rem = 0xFFFF. Same operands with signed_op = 0 → quot = 0x7FFC, rem = 0x0001.
- Divide by zero: 0x1234/0x0000 with signed_op = 0 and with signed_op = 1 → quot = 0xFFFF, rem = 0x1234; out_valid 1 cycle after accept.
- Signed overflow: 0x8000/0xFFFF with signed_op = 1 → quot = 0x8000, rem = 0x0000 in 1 cycle. Same with signed_op = 0 → quot = 0x0000, rem = 0x8000 after 18 cycles.
- Backpressure: 0xFFFF/0x0001 unsigned, out_ready held 0 for 5 cycles → quot = 0xFFFF, rem = 0 held stable; in_ready = 0 until the cycle after the out_ready handshake.
- Kill/reset:
  - Assert kill at cycle 8 of CALC → IDLE next cycle, out_valid never rises; the next op, 50/5, yields quot = 10, rem = 0.
  - Pulse rst_n low mid-CALC → all outputs return to reset values asynchronously.
